// File: rtl/data_path_if.sv
// Control/memory-facing signal bundle of the teaching-computer datapath.
// DATA_PATH_SEL_CHECK_EN adds the sticky sel_error flag to the bundle.
interface data_path_if;
   // Strobes and selects are level signals sampled on the rising clock edge.
   // There is no valid/ready handshake: a strobe held high for one edge acts once.
   logic       IR_Load;
   logic       MAR_Load;
   logic       PC_Load;
   logic       PC_Inc;
   logic       A_Load;
   logic       B_Load;
   logic       CCR_Load;
   logic [2:0] ALU_Sel;
   logic [1:0] Bus1_Sel;
   logic [1:0] Bus2_Sel;
   logic [7:0] from_memory;
   logic [7:0] IR;
   logic [3:0] CCR_Result;
   logic [7:0] address;
   logic [7:0] to_memory;
`ifdef DATA_PATH_SEL_CHECK_EN
   logic       sel_error;

   modport master (
      output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
             ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
      input  IR, CCR_Result, address, to_memory, sel_error
   );
   modport slave (
      input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
             ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
      output IR, CCR_Result, address, to_memory, sel_error
   );
`else
   modport master (
      output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
             ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
      input  IR, CCR_Result, address, to_memory
   );
   modport slave (
      input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
             ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
      output IR, CCR_Result, address, to_memory
   );
`endif
endinterface

// File: rtl/data_path.sv
// 8-bit datapath: IR/MAR/PC/A/B/CCR registers, Bus1/Bus2 muxes and ALU.
// Optional DATA_PATH_SEL_CHECK_EN adds a sticky sel_error on reserved select code 11.
module data_path #(
   parameter logic [7:0] PC_RESET  = 8'h00,
   parameter logic [7:0] MAR_RESET = 8'h00
) (
   input logic        Clk,
   input logic        Reset,
   data_path_if.slave bus
);

   logic [7:0] ir_q, mar_q, pc_q, a_q, b_q;
   logic [3:0] ccr_q;
   logic [7:0] bus1, bus2;
   logic [7:0] alu_result;
   logic [3:0] alu_flags;

   always_comb begin
      bus1 = 8'h00;
      case (bus.Bus1_Sel)
         2'b00:   bus1 = pc_q;
         2'b01:   bus1 = a_q;
         2'b10:   bus1 = b_q;
         default: bus1 = 8'h00;
      endcase
   end

   always_comb begin
      bus2 = 8'h00;
      case (bus.Bus2_Sel)
         2'b00:   bus2 = alu_result;
         2'b01:   bus2 = bus1;
         2'b10:   bus2 = bus.from_memory;
         default: bus2 = 8'h00;
      endcase
   end

   // Add/sub share one 9-bit path; INC/DEC reuse it with a constant 1 operand.
   logic [7:0] opnd;
   logic [8:0] wide;
   logic       is_sub, ovf, cry;

   always_comb begin
      opnd       = b_q;
      wide       = 9'h000;
      is_sub     = 1'b0;
      ovf        = 1'b0;
      cry        = 1'b0;
      alu_result = 8'h00;
      case (bus.ALU_Sel)
         3'b000, 3'b101: begin
            opnd       = (bus.ALU_Sel == 3'b101) ? 8'h01 : b_q;
            wide       = {1'b0, bus1} + {1'b0, opnd};
            alu_result = wide[7:0];
            cry        = wide[8];
            ovf        = (bus1[7] == opnd[7]) && (alu_result[7] != bus1[7]);
         end
         3'b001, 3'b110: begin
            is_sub     = 1'b1;
            opnd       = (bus.ALU_Sel == 3'b110) ? 8'h01 : b_q;
            wide       = {1'b0, bus1} - {1'b0, opnd};
            alu_result = wide[7:0];
            cry        = wide[8];
            ovf        = (bus1[7] != opnd[7]) && (alu_result[7] != bus1[7]);
         end
         3'b010:  alu_result = bus1 & b_q;
         3'b011:  alu_result = bus1 | b_q;
         3'b100:  alu_result = bus1 ^ b_q;
         default: alu_result = ~bus1;
      endcase
      alu_flags = {alu_result[7], (alu_result == 8'h00), ovf, cry};
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ir_q  <= 8'h00;
         mar_q <= MAR_RESET;
         pc_q  <= PC_RESET;
         a_q   <= 8'h00;
         b_q   <= 8'h00;
         ccr_q <= 4'h0;
      end else begin
         if (bus.IR_Load)  ir_q  <= bus2;
         if (bus.MAR_Load) mar_q <= bus2;
         if (bus.A_Load)   a_q   <= bus2;
         if (bus.B_Load)   b_q   <= bus2;
         if (bus.CCR_Load) ccr_q <= alu_flags;
         // Branch load takes priority over sequential increment.
         if (bus.PC_Load)     pc_q <= bus2;
         else if (bus.PC_Inc) pc_q <= pc_q + 8'h01;
      end
   end

   assign bus.IR         = ir_q;
   assign bus.CCR_Result = ccr_q;
   assign bus.address    = mar_q;
   assign bus.to_memory  = bus1;

`ifdef DATA_PATH_SEL_CHECK_EN
   logic sel_error_q;
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         sel_error_q <= 1'b0;
      else if ((bus.Bus1_Sel == 2'b11) || (bus.Bus2_Sel == 2'b11))
         sel_error_q <= 1'b1;
   end
   assign bus.sel_error = sel_error_q;
`endif

   // is_sub only documents which arithmetic path is active.
   logic unused_ok;
   assign unused_ok = is_sub;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed test-plan cases plus random
// strobe traffic checked against an integer-arithmetic reference model.
module tb_data_path;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   data_path_if dp_if ();

   data_path dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (dp_if)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int   m_ir, m_mar, m_pc, m_a, m_b;
   logic [3:0] m_ccr;
   logic       m_sel_err;

   // Expected {IR, address, CCR} after the next edge
   logic [19:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int to_signed8(input int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   // Result and {N,Z,V,C} computed from the arithmetic definitions.
   function automatic void alu_model(input int sel, input int x, input int y,
                                     output int r, output logic [3:0] f);
      int   raw, sres;
      logic c, v;
      c = 1'b0; v = 1'b0; sres = 0; raw = 0;
      case (sel)
         0: begin raw = x + y; c = (raw > 255); sres = to_signed8(x) + to_signed8(y); end
         1: begin raw = x - y; c = (x < y);     sres = to_signed8(x) - to_signed8(y); end
         2: raw = x & y;
         3: raw = x | y;
         4: raw = x ^ y;
         5: begin raw = x + 1; c = (raw > 255); sres = to_signed8(x) + 1; end
         6: begin raw = x - 1; c = (x < 1);     sres = to_signed8(x) - 1; end
         default: raw = 255 - x;
      endcase
      if (sel <= 1 || sel == 5 || sel == 6) v = (sres > 127) || (sres < -128);
      r = raw & 255;
      f = {(r > 127), (r == 0), v, c};
   endfunction

   task automatic model_reset();
      m_ir = 0; m_mar = 0; m_pc = 0; m_a = 0; m_b = 0; m_ccr = 4'h0; m_sel_err = 1'b0;
   endtask

   // Drive one cycle of strobes, check Bus1 before the edge, check registers after.
   task automatic step(input logic ir_ld, input logic mar_ld, input logic pc_ld,
                       input logic pc_inc, input logic a_ld, input logic b_ld,
                       input logic ccr_ld, input int alu, input int b1, input int b2,
                       input int mem);
      int         bus1_v, bus2_v, r;
      logic [3:0] f;
      logic [19:0] e;
      dp_if.IR_Load     = ir_ld;
      dp_if.MAR_Load    = mar_ld;
      dp_if.PC_Load     = pc_ld;
      dp_if.PC_Inc      = pc_inc;
      dp_if.A_Load      = a_ld;
      dp_if.B_Load      = b_ld;
      dp_if.CCR_Load    = ccr_ld;
      dp_if.ALU_Sel     = 3'(alu);
      dp_if.Bus1_Sel    = 2'(b1);
      dp_if.Bus2_Sel    = 2'(b2);
      dp_if.from_memory = 8'(mem);
      #1;
      bus1_v = (b1 == 0) ? m_pc : (b1 == 1) ? m_a : (b1 == 2) ? m_b : 0;
      alu_model(alu, bus1_v, m_b, r, f);
      bus2_v = (b2 == 0) ? r : (b2 == 1) ? bus1_v : (b2 == 2) ? mem : 0;
      check("to_memory", dp_if.to_memory, bus1_v);
      if (ir_ld)  m_ir  = bus2_v;
      if (mar_ld) m_mar = bus2_v;
      if (a_ld)   m_a   = bus2_v;
      if (b_ld)   m_b   = bus2_v;
      if (ccr_ld) m_ccr = f;
      if (pc_ld)       m_pc = bus2_v;
      else if (pc_inc) m_pc = (m_pc + 1) % 256;
      if (b1 == 3 || b2 == 3) m_sel_err = 1'b1;
      exp_q.push_back({8'(m_ir), 8'(m_mar), m_ccr});
      @(posedge Clk);
      #1;
      e = exp_q.pop_front();
      check("ir", dp_if.IR, e[19:12]);
      check("address", dp_if.address, e[11:4]);
      check("ccr", dp_if.CCR_Result, e[3:0]);
`ifdef DATA_PATH_SEL_CHECK_EN
      check("sel_error", dp_if.sel_error, m_sel_err);
`endif
   endtask

   task automatic idle(input int b1);
      step(0, 0, 0, 0, 0, 0, 0, 0, b1, 1, 0);
   endtask

   task automatic load_a(input int v);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, 2, v);
   endtask

   task automatic load_b(input int v);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 2, v);
   endtask

   initial begin
      Reset = 1'b0;
      dp_if.IR_Load = 0; dp_if.MAR_Load = 0; dp_if.PC_Load = 0; dp_if.PC_Inc = 0;
      dp_if.A_Load = 0; dp_if.B_Load = 0; dp_if.CCR_Load = 0;
      dp_if.ALU_Sel = 3'd0; dp_if.Bus1_Sel = 2'd0; dp_if.Bus2_Sel = 2'd1;
      dp_if.from_memory = 8'h00;
      model_reset();
      #12;
      check("rst_ir", dp_if.IR, 8'h00);
      check("rst_addr", dp_if.address, 8'h00);
      check("rst_ccr", dp_if.CCR_Result, 4'h0);
      check("rst_pc", dp_if.to_memory, 8'h00);
      @(negedge Clk);
      Reset = 1'b1;

      // Fetch: MAR <= PC, then IR <= mem, PC++
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("fetch_addr", dp_if.address, 8'h00);
      step(1, 0, 0, 1, 0, 0, 0, 0, 0, 2, 8'h86);
      check("fetch_ir", dp_if.IR, 8'h86);
      idle(0);
      check("fetch_pc", dp_if.to_memory, 8'h01);

      // ADD_AB: 7F + 01
      load_a(8'h7F); load_b(8'h01);
      step(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
      check("add_ccr", dp_if.CCR_Result, 4'b1010);
      idle(1);
      check("add_a", dp_if.to_memory, 8'h80);

      // SUB to zero
      load_a(8'h05); load_b(8'h05);
      step(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
      check("subz_ccr", dp_if.CCR_Result, 4'b0100);
      idle(1);
      check("subz_a", dp_if.to_memory, 8'h00);

      // SUB with borrow: 03 - 05 = FE, N=1 C=1
      load_a(8'h03); load_b(8'h05);
      step(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
      check("subb_ccr", dp_if.CCR_Result, 4'b1001);
      idle(1);
      check("subb_a", dp_if.to_memory, 8'hFE);

      // STA_DIR data path
      load_a(8'h3C);
      idle(1);
      check("sta_data", dp_if.to_memory, 8'h3C);
      check("sta_addr_hold", dp_if.address, 8'h00);
      step(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      check("sta_addr", dp_if.address, 8'h3C);

      // PC wrap and load-over-inc priority
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 8'hFF);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      idle(0);
      check("pc_wrap", dp_if.to_memory, 8'h00);
      step(0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 8'h20);
      idle(0);
      check("pc_prio", dp_if.to_memory, 8'h20);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 255));
      end

      // Mid-cycle reset with strobes active
      load_a(8'h5A); load_b(8'hA5);
      step(1, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
      dp_if.A_Load = 1; dp_if.PC_Inc = 1; dp_if.CCR_Load = 1;
      dp_if.Bus1_Sel = 2'd1; dp_if.Bus2_Sel = 2'd2; dp_if.from_memory = 8'h77;
      #2;
      Reset = 1'b0;
      #1;
      model_reset();
      check("mid_rst_ir", dp_if.IR, 8'h00);
      check("mid_rst_addr", dp_if.address, 8'h00);
      check("mid_rst_ccr", dp_if.CCR_Result, 4'h0);
      check("mid_rst_a", dp_if.to_memory, 8'h00);
`ifdef DATA_PATH_SEL_CHECK_EN
      check("mid_rst_sel", dp_if.sel_error, 1'b0);
`endif
      @(negedge Clk);
      Reset = 1'b1;
      step(1, 0, 0, 1, 0, 0, 0, 0, 0, 2, 8'h42);
      check("post_rst_ir", dp_if.IR, 8'h42);
      idle(0);
      check("post_rst_pc", dp_if.to_memory, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 8-bit datapath of the teaching computer.
- Sits directly downstream of control_unit: it consumes every load, increment and select strobe that control_unit drives.
- Feeds IR and CCR_Result back to control_unit, and drives address and write data to the memory block.
- Contains IR, MAR, PC, A, B and CCR registers, the Bus1/Bus2 multiplexers and the ALU.

Parameters:
- PC_RESET, 8'h00, value loaded into PC on reset (program entry point).
- MAR_RESET, 8'h00, value loaded into MAR on reset.

Ports:
- Clk  input  1  system clock; all registers update on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IR_Load  input  1  IR <= Bus2.
- MAR_Load  input  1  MAR <= Bus2.
- PC_Load  input  1  PC <= Bus2.
- PC_Inc  input  1  PC <= PC + 1.
- A_Load  input  1  A <= Bus2.
- B_Load  input  1  B <= Bus2.
- CCR_Load  input  1  CCR <= ALU flags NZVC.
- ALU_Sel  input  3  ALU operation.
- Bus1_Sel  input  2  Bus1 source.
- Bus2_Sel  input  2  Bus2 source.
- from_memory  input  8  memory read data.
- IR  output  8  instruction register, to control_unit.
- CCR_Result  output  4  {N,Z,V,C}, to control_unit.
- address  output  8  memory address; equals MAR.
- to_memory  output  8  memory write data; equals Bus1.

Behaviour:
- Reset low, asynchronous:
  - IR=0, A=0, B=0, CCR=0.
  - PC=PC_RESET, MAR=MAR_RESET.
  - Outputs settle combinationally from these registers.
- Bus1 (combinational):
  - 00 = PC, 01 = A, 10 = B, 11 = 8'h00.
- Bus2 (combinational):
  - 00 = ALU_Result, 01 = Bus1, 10 = from_memory, 11 = 8'h00.
- ALU inputs: operand X = Bus1, operand Y = B register. All operations are 8-bit and wrap modulo 256.
- ALU_Sel encoding:
  - 000 ADD: X+Y
  - 001 SUB: X-Y
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 INC X: X+1
  - 110 DEC X: X-1
  - 111 NOT X
- Flags, computed combinationally every cycle:
  - N = result[7].
  - Z = (result == 0).
  - ADD/INC: C = carry out of bit 7; V = signed overflow (operands share a sign and the result sign differs).
  - SUB/DEC: C = borrow (X < subtrahend, unsigned); V = signed overflow of the subtraction.
  - Logic ops: V=0, C=0.
- CCR captures the flags only when CCR_Load=1; otherwise it holds.
- Load latency: every load is visible on outputs one cycle after the strobe edge.
- Single Bus2: several simultaneous loads all capture the same Bus2 value.
- PC priority:
  - PC_Load=1 overrides PC_Inc (branch wins).
  - PC_Inc alone: 8'hFF wraps to 8'h00.
  - Neither: hold.
- Loads, PC_Inc and CCR_Load use the value present before the edge. PC_Inc together with Bus1_Sel=00 puts the old PC on Bus1 in that cycle.
- Reset asserted mid-instruction: all registers clear immediately, regardless of strobes; the first edge after Reset rises behaves normally.
- No internal state machine; sequencing is owned entirely by control_unit.

Optional Feature:
- Macro: DATA_PATH_SEL_CHECK_EN.
- Defined:
  - Adds output port sel_error (1 bit).
  - sel_error is registered and sticky; set on the first edge where Bus1_Sel==2'b11 or Bus2_Sel==2'b11.
  - Cleared only by reset; reset value 0.
  - Bus values for code 11 stay 8'h00.
- Not defined: port and logic absent; code 11 silently drives 8'h00.

Test Plan:
- Reset then fetch.
  - Stimulus: Reset=0 then 1; Bus1_Sel=00, Bus2_Sel=01, MAR_Load=1; next cycle PC_Inc=1, from_memory=8'h86, Bus2_Sel=10, IR_Load=1.
  - Required: address=8'h00, then PC=8'h01 and IR=8'h86.
- ADD_AB.
  - Stimulus: A=8'h7F, B=8'h01; Bus1_Sel=01, Bus2_Sel=00, ALU_Sel=000, A_Load=1, CCR_Load=1.
  - Required: A=8'h80, CCR_Result=4'b1010 (N=1, V=1).
- SUB to zero.
  - Stimulus: A=8'h05, B=8'h05, SUB with CCR_Load=1.
  - Required: A=8'h00, CCR_Result=4'b0100.
- SUB with borrow.
  - Stimulus: A=8'h03, B=8'h05, SUB.
  - Required: result 8'hFE, C=1, N=1.
- STA_DIR data.
  - Stimulus: A=8'h3C, Bus1_Sel=01.
  - Required: to_memory=8'h3C; address unchanged until MAR_Load.
- PC boundaries.
  - PC=8'hFF with PC_Inc=1 -> PC=8'h00.
  - PC_Load=1 and PC_Inc=1 with Bus2=8'h20 -> PC=8'h20.
  - Reset pulled low mid-sequence -> all registers cleared within the same cycle.
